// File: rtl/drr_4_tx_sched_pkg.sv
// ---------------------------------------------------------------------------
// drr_4_tx_sched_pkg
// Shared definitions for the 4-queue deficit-round-robin TX scheduler:
//   NUM_Q / QIDX_W   queue count and queue-index width
//   sched_state_t    scheduler FSM state encoding (IDLE/VISIT/GRANT/BUSY)
//   credit_cmd_t     command set understood by the deficit credit bank
//   idx2onehot()     queue index -> one-hot queue select
//   onehot2idx()     one-hot queue select -> queue index
// ---------------------------------------------------------------------------
package drr_4_tx_sched_pkg;

  localparam int NUM_Q  = 4;
  localparam int QIDX_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_VISIT = 2'd1,
    ST_GRANT = 2'd2,
    ST_BUSY  = 2'd3
  } sched_state_t;

  typedef enum logic [1:0] {
    CR_NONE = 2'd0,
    CR_ADD  = 2'd1,
    CR_SUB  = 2'd2,
    CR_CLR  = 2'd3
  } credit_cmd_t;

  function automatic logic [NUM_Q-1:0] idx2onehot(input logic [QIDX_W-1:0] idx);
    logic [NUM_Q-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  // Lowest set bit wins; an all-zero input maps to index 0.
  function automatic logic [QIDX_W-1:0] onehot2idx(input logic [NUM_Q-1:0] oh);
    logic [QIDX_W-1:0] idx;
    idx = '0;
    for (int i = NUM_Q - 1; i >= 0; i--) begin
      if (oh[i]) idx = QIDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/drr_4_tx_sched_if.sv
// ---------------------------------------------------------------------------
// drr_4_tx_sched_if
// Grant/handshake bus between the DRR scheduler and the TX packet engine.
//   tx_valid  grant offered to the TX engine
//   tx_ready  TX engine accepts the grant (handshake on tx_valid & tx_ready)
//   tx_qsel   one-hot granted queue
//   tx_len    granted packet length in bytes
//   tx_done   1-cycle pulse: granted packet transmitted and popped
// Modports: master = scheduler side, slave = TX engine side.
// ---------------------------------------------------------------------------
interface drr_4_tx_sched_if
  import drr_4_tx_sched_pkg::*;
#(
  parameter int LEN_W = 16
) ();

  logic             tx_valid;
  logic             tx_ready;
  logic [NUM_Q-1:0] tx_qsel;
  logic [LEN_W-1:0] tx_len;
  logic             tx_done;

  modport master (
    output tx_valid,
    output tx_qsel,
    output tx_len,
    input  tx_ready,
    input  tx_done
  );

  modport slave (
    input  tx_valid,
    input  tx_qsel,
    input  tx_len,
    output tx_ready,
    output tx_done
  );

endinterface

// File: rtl/drr_4_tx_sched_credit_bank.sv
// ---------------------------------------------------------------------------
// drr_credit_bank
// Holds the per-queue byte deficit counters of the DRR scheduler.
//   sys_clk, sys_rst  clock / synchronous active-high reset (deficits -> 0)
//   cmd, cmd_idx      one command per cycle on one queue:
//                       CR_ADD  saturating add of add_amt
//                       CR_SUB  subtract sub_amt, floored at 0
//                       CR_CLR  clear to 0
//   add_amt           quantum to add
//   sub_amt           packet length to subtract
//   rd_idx            queue whose deficit is shown on rd_deficit
//   rd_deficit        current deficit of queue rd_idx
// ---------------------------------------------------------------------------
module drr_credit_bank
  import drr_4_tx_sched_pkg::*;
#(
  parameter int LEN_W = 16,
  parameter int QNT_W = 16,
  parameter int DEF_W = 18
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  credit_cmd_t       cmd,
  input  logic [QIDX_W-1:0] cmd_idx,
  input  logic [QNT_W-1:0]  add_amt,
  input  logic [LEN_W-1:0]  sub_amt,
  input  logic [QIDX_W-1:0] rd_idx,
  output logic [DEF_W-1:0]  rd_deficit
);

  logic [DEF_W-1:0] deficit_reg [NUM_Q];

  generate
    for (genvar gi = 0; gi < NUM_Q; gi++) begin : g_credit
      // One extra bit catches the carry so the add can clamp instead of wrap.
      logic [DEF_W:0]   sum_wide;
      logic [DEF_W-1:0] sub_ext;

      assign sum_wide = {1'b0, deficit_reg[gi]} + (DEF_W+1)'(add_amt);
      assign sub_ext  = DEF_W'(sub_amt);

      always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
          deficit_reg[gi] <= '0;
        end else if (cmd_idx == QIDX_W'(gi)) begin
          case (cmd)
            CR_ADD: deficit_reg[gi] <= sum_wide[DEF_W] ? {DEF_W{1'b1}}
                                                       : sum_wide[DEF_W-1:0];
            CR_SUB: deficit_reg[gi] <= (deficit_reg[gi] >= sub_ext)
                                       ? (deficit_reg[gi] - sub_ext) : '0;
            CR_CLR: deficit_reg[gi] <= '0;
            default: ;
          endcase
        end
      end
    end
  endgenerate

  assign rd_deficit = deficit_reg[rd_idx];

endmodule

// File: rtl/drr_4_tx_sched.sv
// ---------------------------------------------------------------------------
// drr_4_tx_sched
// Deficit-round-robin TX scheduler for 4 send queues feeding one TX engine.
// A queue may send its head packet only while its byte credit covers the
// packet length, giving byte-fair, quantum-weighted sharing.
//   sys_clk, sys_rst  clock / synchronous active-high reset
//   sched_en          0 stops new rounds; an in-flight packet completes
//   q_valid[3:0]      head packet present per queue
//   q_len             packed head lengths, queue i at [i*LEN_W +: LEN_W]
//   cfg_quantum       packed quanta, same packing; read only when credit is added
//   tx                grant bus (master): tx_valid/tx_qsel/tx_len out,
//                     tx_ready/tx_done in
//   sched_busy        FSM is not in IDLE
// ---------------------------------------------------------------------------
module drr_4_tx_sched
  import drr_4_tx_sched_pkg::*;
#(
  parameter int LEN_W = 16,
  parameter int QNT_W = 16,
  parameter int DEF_W = 18
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic                   sched_en,
  input  logic [NUM_Q-1:0]       q_valid,
  input  logic [NUM_Q*LEN_W-1:0] q_len,
  input  logic [NUM_Q*QNT_W-1:0] cfg_quantum,
  drr_4_tx_sched_if.master       tx,
  output logic                   sched_busy
);

  sched_state_t      state_reg;
  logic [QIDX_W-1:0] cur_q_reg;
  logic              tx_valid_reg;
  logic [NUM_Q-1:0]  tx_qsel_reg;
  logic [LEN_W-1:0]  tx_len_reg;

  logic [LEN_W-1:0]  q_len_arr   [NUM_Q];
  logic [QNT_W-1:0]  quantum_arr [NUM_Q];

  generate
    for (genvar gi = 0; gi < NUM_Q; gi++) begin : g_unpack
      assign q_len_arr[gi]   = q_len[gi*LEN_W +: LEN_W];
      assign quantum_arr[gi] = cfg_quantum[gi*QNT_W +: QNT_W];
    end
  endgenerate

  // Wrap-around pick: scan from cur_q+4 (== cur_q) down to cur_q+1 so the
  // nearest valid queue after cur_q overwrites any farther one. cur_q itself
  // is only chosen when it is the sole valid queue.
  logic [NUM_Q-1:0]  pick_oh;
  logic [QIDX_W-1:0] pick_cand;
  logic [QIDX_W-1:0] pick_idx;

  always_comb begin
    pick_oh   = '0;
    pick_cand = cur_q_reg;
    for (int k = NUM_Q; k >= 1; k--) begin
      pick_cand = cur_q_reg + QIDX_W'(k);
      if (q_valid[pick_cand]) pick_oh = idx2onehot(pick_cand);
    end
    pick_idx = onehot2idx(pick_oh);
  end

  logic             start_round;
  logic [DEF_W-1:0] cur_deficit;
  logic             eligible;

  assign start_round = sched_en && (|q_valid);
  assign eligible    = q_valid[cur_q_reg] &&
                       (cur_deficit >= DEF_W'(q_len_arr[cur_q_reg]));

  // Credit-bank commands follow the current state's transition decision.
  credit_cmd_t       bank_cmd;
  logic [QIDX_W-1:0] bank_idx;

  always_comb begin
    bank_cmd = CR_NONE;
    bank_idx = cur_q_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start_round) begin
          bank_cmd = CR_ADD;
          bank_idx = pick_idx;
        end
      end
      // A queue that ran empty forfeits its leftover credit.
      ST_VISIT: if (!q_valid[cur_q_reg]) bank_cmd = CR_CLR;
      ST_GRANT: if (tx.tx_ready)         bank_cmd = CR_SUB;
      default: ;
    endcase
  end

  drr_credit_bank #(
    .LEN_W (LEN_W),
    .QNT_W (QNT_W),
    .DEF_W (DEF_W)
  ) u_bank (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .cmd        (bank_cmd),
    .cmd_idx    (bank_idx),
    .add_amt    (quantum_arr[bank_idx]),
    .sub_amt    (tx_len_reg),
    .rd_idx     (cur_q_reg),
    .rd_deficit (cur_deficit)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_reg    <= ST_IDLE;
      cur_q_reg    <= '1;
      tx_valid_reg <= 1'b0;
      tx_qsel_reg  <= '0;
      tx_len_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start_round) begin
            cur_q_reg <= pick_idx;
            state_reg <= ST_VISIT;
          end
        end
        ST_VISIT: begin
          if (eligible) begin
            tx_valid_reg <= 1'b1;
            tx_qsel_reg  <= idx2onehot(cur_q_reg);
            tx_len_reg   <= q_len_arr[cur_q_reg];
            state_reg    <= ST_GRANT;
          end else begin
            state_reg <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          if (tx.tx_ready) begin
            tx_valid_reg <= 1'b0;
            state_reg    <= ST_BUSY;
          end
        end
        // Back to VISIT, not IDLE: the same queue keeps sending on its
        // remaining credit without receiving another quantum.
        ST_BUSY: if (tx.tx_done) state_reg <= ST_VISIT;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign tx.tx_valid = tx_valid_reg;
  assign tx.tx_qsel  = tx_qsel_reg;
  assign tx.tx_len   = tx_len_reg;
  assign sched_busy  = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_drr_4_tx_sched.sv
module tb_drr_4_tx_sched;

  localparam int DMAX = 262143;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        sched_en;
  logic [3:0]  q_valid;
  logic [63:0] q_len;
  logic [63:0] cfg_quantum;
  logic        sched_busy;

  int checks   = 0;
  int failures = 0;

  drr_4_tx_sched_if #(.LEN_W(16)) tx_if ();

  drr_4_tx_sched dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .sched_en    (sched_en),
    .q_valid     (q_valid),
    .q_len       (q_len),
    .cfg_quantum (cfg_quantum),
    .tx          (tx_if),
    .sched_busy  (sched_busy)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers (stimulus / observation only) ----------------
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  function automatic int get_def(input int i);
    case (i)
      0: return int'(dut.u_bank.deficit_reg[0]);
      1: return int'(dut.u_bank.deficit_reg[1]);
      2: return int'(dut.u_bank.deficit_reg[2]);
      default: return int'(dut.u_bank.deficit_reg[3]);
    endcase
  endfunction

  task automatic set_q(input int i, input int qnt, input int len);
    cfg_quantum[i*16 +: 16] = 16'(qnt);
    q_len[i*16 +: 16]       = 16'(len);
  endtask

  task automatic do_reset();
    sys_rst = 1'b1; sched_en = 1'b1; q_valid = 4'b0; q_len = '0; cfg_quantum = '0;
    tx_if.tx_ready = 1'b0; tx_if.tx_done = 1'b0;
    tick(); tick();
    sys_rst = 1'b0;
  endtask

  task automatic wait_valid(input int limit, output int cyc, output bit ok);
    cyc = 0; ok = 1'b0;
    while (cyc < limit) begin
      if (tx_if.tx_valid === 1'b1) begin ok = 1'b1; return; end
      tick(); cyc++;
    end
  endtask

  // ---------------- behavioural DRR reference model ----------------
  int  qnt[4];
  int  pk[4][$];
  int  m_def[4];
  int  m_cur;
  bit  m_after_done;

  task automatic drive_from_model();
    for (int i = 0; i < 4; i++) begin
      q_valid[i]        = (pk[i].size() > 0);
      cfg_quantum[i*16 +: 16] = 16'(qnt[i]);
      q_len[i*16 +: 16] = (pk[i].size() > 0) ? 16'(pk[i][0]) : 16'd0;
    end
  endtask

  // Returns the queue that receives the next grant, or -1 if none ever will.
  task automatic model_next(output int g);
    int p;
    g = -1;
    if (m_after_done) begin
      m_after_done = 1'b0;
      if (pk[m_cur].size() > 0 && m_def[m_cur] >= pk[m_cur][0]) begin g = m_cur; return; end
      if (pk[m_cur].size() == 0) m_def[m_cur] = 0;
    end
    for (int guard = 0; guard < 1000; guard++) begin
      p = -1;
      for (int k = 1; k <= 4; k++)
        if (p < 0 && pk[(m_cur + k) % 4].size() > 0) p = (m_cur + k) % 4;
      if (p < 0) return;
      m_cur = p;
      m_def[p] = (m_def[p] + qnt[p] > DMAX) ? DMAX : m_def[p] + qnt[p];
      if (m_def[p] >= pk[p][0]) begin g = p; return; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int cyc; bit ok;
    do_reset();
    tick(); tick();
    checks++; if (tx_if.tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid: got %b expected 0", tx_if.tx_valid); end
    checks++; if (tx_if.tx_qsel !== 4'b0) begin failures++; $display("FAIL reset_tx_qsel: got %b expected 0000", tx_if.tx_qsel); end
    checks++; if (tx_if.tx_len !== 16'd0) begin failures++; $display("FAIL reset_tx_len: got %0d expected 0", tx_if.tx_len); end
    checks++; if (sched_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", sched_busy); end
    for (int i = 0; i < 4; i++) set_q(i, 1500, 100);
    q_valid = 4'b1111;
    tick();
    checks++; if (tx_if.tx_valid !== 1'b0 || sched_busy !== 1'b1) begin failures++; $display("FAIL latency_n1: valid=%b busy=%b expected valid=0 busy=1", tx_if.tx_valid, sched_busy); end
    tick();
    checks++; if (tx_if.tx_valid !== 1'b1) begin failures++; $display("FAIL latency_n2: tx_valid=%b expected 1", tx_if.tx_valid); end
    wait_valid(10, cyc, ok);
    checks++; if (tx_if.tx_qsel !== 4'b0001) begin failures++; $display("FAIL first_pick: got %b expected 0001", tx_if.tx_qsel); end
    $display("test_reset: first grant qsel=%b", tx_if.tx_qsel);
  endtask

  task automatic test_order();
    int exp_order[12] = '{0, 1, 2, 3, 0, 0, 1, 1, 2, 2, 3, 3};
    int cyc; bit ok;
    do_reset();
    for (int i = 0; i < 4; i++) set_q(i, 1500, 1000);
    q_valid = 4'b1111;
    tx_if.tx_ready = 1'b1;
    for (int n = 0; n < 12; n++) begin
      wait_valid(100, cyc, ok);
      checks++; if (!ok) begin failures++; $display("FAIL order_timeout: grant %0d not offered", n); break; end
      checks++;
      if (tx_if.tx_qsel !== (4'b0001 << exp_order[n])) begin
        failures++; $display("FAIL order_%0d: qsel=%b expected q%0d", n, tx_if.tx_qsel, exp_order[n]);
      end
      $display("test_order: grant %0d qsel=%b len=%0d", n, tx_if.tx_qsel, tx_if.tx_len);
      tick(); tick(); tick();
      tx_if.tx_done = 1'b1; tick(); tx_if.tx_done = 1'b0;
    end
    tx_if.tx_ready = 1'b0;
  endtask

  task automatic test_accumulate();
    int cyc; bit ok;
    do_reset();
    set_q(2, 500, 1200);
    q_valid = 4'b0100;
    wait_valid(50, cyc, ok);
    checks++; if (!ok || cyc != 6) begin failures++; $display("FAIL accum_latency: ok=%b cycles=%0d expected 6", ok, cyc); end
    checks++; if (tx_if.tx_qsel !== 4'b0100 || tx_if.tx_len !== 16'd1200) begin failures++; $display("FAIL accum_grant: qsel=%b len=%0d expected 0100/1200", tx_if.tx_qsel, tx_if.tx_len); end
    checks++; if (get_def(2) != 1500) begin failures++; $display("FAIL accum_def_pre: got %0d expected 1500", get_def(2)); end
    tx_if.tx_ready = 1'b1; tick(); tx_if.tx_ready = 1'b0;
    checks++; if (get_def(2) != 300 || tx_if.tx_valid !== 1'b0) begin failures++; $display("FAIL accum_def_post: def=%0d valid=%b expected 300/0", get_def(2), tx_if.tx_valid); end
    $display("test_accumulate: cycles=%0d deficit2=%0d", cyc, get_def(2));
  endtask

  task automatic test_stall();
    int cyc; bit ok;
    do_reset();
    set_q(1, 1000, 400);
    q_valid = 4'b0010;
    wait_valid(20, cyc, ok);
    checks++; if (!ok) begin failures++; $display("FAIL stall_timeout: no grant"); end
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (tx_if.tx_valid !== 1'b1 || tx_if.tx_qsel !== 4'b0010 || tx_if.tx_len !== 16'd400 || get_def(1) != 1000) begin
        failures++; $display("FAIL stall_hold_%0d: valid=%b qsel=%b len=%0d def=%0d expected 1/0010/400/1000", c, tx_if.tx_valid, tx_if.tx_qsel, tx_if.tx_len, get_def(1));
      end
    end
    tx_if.tx_ready = 1'b1; tick(); tx_if.tx_ready = 1'b0;
    checks++; if (tx_if.tx_valid !== 1'b0 || get_def(1) != 600) begin failures++; $display("FAIL stall_accept: valid=%b def=%0d expected 0/600", tx_if.tx_valid, get_def(1)); end
    $display("test_stall: accepted, deficit1=%0d", get_def(1));
  endtask

  task automatic test_drop();
    int cyc; bit ok;
    do_reset();
    set_q(1, 1500, 600); set_q(3, 1500, 600);
    q_valid = 4'b1010;
    wait_valid(20, cyc, ok);
    checks++; if (tx_if.tx_qsel !== 4'b0010 || get_def(1) != 1500) begin failures++; $display("FAIL drop_grant: qsel=%b def=%0d expected 0010/1500", tx_if.tx_qsel, get_def(1)); end
    tx_if.tx_ready = 1'b1; tick(); tx_if.tx_ready = 1'b0;
    q_valid[1] = 1'b0; tick();
    tx_if.tx_done = 1'b1; tick(); tx_if.tx_done = 1'b0; tick();
    checks++; if (get_def(1) != 0) begin failures++; $display("FAIL drop_clear: def1=%0d expected 0", get_def(1)); end
    wait_valid(20, cyc, ok);
    checks++; if (!ok || tx_if.tx_qsel !== 4'b1000) begin failures++; $display("FAIL drop_next: ok=%b qsel=%b expected 1000", ok, tx_if.tx_qsel); end
    $display("test_drop: next qsel=%b", tx_if.tx_qsel);
  endtask

  task automatic test_rst_mid();
    int cyc; bit ok;
    do_reset();
    set_q(0, 1000, 100);
    q_valid = 4'b0001;
    wait_valid(20, cyc, ok);
    tx_if.tx_ready = 1'b1; tick(); tx_if.tx_ready = 1'b0;
    sys_rst = 1'b1; tick(); sys_rst = 1'b0;
    checks++;
    if (tx_if.tx_valid !== 1'b0 || sched_busy !== 1'b0 || get_def(0) != 0 || get_def(1) != 0) begin
      failures++; $display("FAIL rst_busy: valid=%b busy=%b def0=%0d expected 0/0/0", tx_if.tx_valid, sched_busy, get_def(0));
    end
    wait_valid(20, cyc, ok);
    sys_rst = 1'b1; tick(); sys_rst = 1'b0;
    checks++; if (tx_if.tx_valid !== 1'b0 || tx_if.tx_qsel !== 4'b0) begin failures++; $display("FAIL rst_grant: valid=%b qsel=%b expected 0/0000", tx_if.tx_valid, tx_if.tx_qsel); end
    $display("test_rst_mid: grant abandoned by reset");
  endtask

  task automatic test_sched_en();
    int cyc; bit ok; int bad;
    do_reset();
    set_q(0, 1000, 800); set_q(1, 1000, 800);
    q_valid = 4'b0011;
    wait_valid(20, cyc, ok);
    sched_en = 1'b0;
    tx_if.tx_ready = 1'b1; tick(); tx_if.tx_ready = 1'b0;
    checks++; if (get_def(0) != 200) begin failures++; $display("FAIL en_complete: def0=%0d expected 200", get_def(0)); end
    tick();
    tx_if.tx_done = 1'b1; tick(); tx_if.tx_done = 1'b0;
    tick(); tick();
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (sched_busy !== 1'b0 || tx_if.tx_valid !== 1'b0) bad++;
      tick();
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL en_park: %0d non-idle cycles, expected 0", bad); end
    sched_en = 1'b1;
    wait_valid(20, cyc, ok);
    checks++; if (!ok || tx_if.tx_qsel !== 4'b0010) begin failures++; $display("FAIL en_resume: ok=%b qsel=%b expected 0010", ok, tx_if.tx_qsel); end
    $display("test_sched_en: parked then resumed qsel=%b", tx_if.tx_qsel);
  endtask

  task automatic test_zero_quantum();
    int cyc; bit ok; int bad;
    do_reset();
    set_q(0, 0, 0);
    q_valid = 4'b0001;
    wait_valid(20, cyc, ok);
    checks++; if (!ok || tx_if.tx_qsel !== 4'b0001 || tx_if.tx_len !== 16'd0) begin failures++; $display("FAIL zq_len0: ok=%b qsel=%b len=%0d expected 0001/0", ok, tx_if.tx_qsel, tx_if.tx_len); end
    do_reset();
    set_q(0, 0, 5); set_q(1, 100, 50);
    q_valid = 4'b0011;
    wait_valid(20, cyc, ok);
    checks++; if (!ok || tx_if.tx_qsel !== 4'b0010) begin failures++; $display("FAIL zq_other: ok=%b qsel=%b expected 0010", ok, tx_if.tx_qsel); end
    tx_if.tx_ready = 1'b1; tick(); tx_if.tx_ready = 1'b0;
    q_valid = 4'b0001; tx_if.tx_done = 1'b1; tick(); tx_if.tx_done = 1'b0;
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      if (tx_if.tx_valid === 1'b1) bad++;
      tick();
    end
    checks++; if (bad != 0 || get_def(0) != 0) begin failures++; $display("FAIL zq_starve: grants=%0d def0=%0d expected 0/0", bad, get_def(0)); end
    $display("test_zero_quantum: q0 never granted with len 5");
  endtask

  task automatic test_random();
    int cyc; bit ok; int g; int len; int bad;
    for (int run = 0; run < 4; run++) begin
      do_reset();
      for (int i = 0; i < 4; i++) begin
        qnt[i] = $urandom_range(2000, 100);
        pk[i].delete();
        for (int n = $urandom_range(6, 0); n > 0; n--)
          pk[i].push_back(($urandom_range(7, 0) == 0) ? 0 : $urandom_range(2500, 1));
        m_def[i] = 0;
      end
      m_cur = 3; m_after_done = 1'b0;
      drive_from_model();
      forever begin
        model_next(g);
        if (g < 0) break;
        len = pk[g][0];
        wait_valid(600, cyc, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rand_timeout: expected grant to q%0d", g); break; end
        checks++;
        if (tx_if.tx_qsel !== (4'b0001 << g) || tx_if.tx_len !== 16'(len)) begin
          failures++; $display("FAIL rand_grant: qsel=%b len=%0d expected q%0d len=%0d", tx_if.tx_qsel, tx_if.tx_len, g, len);
        end
        repeat ($urandom_range(3, 0)) tick();
        tx_if.tx_ready = 1'b1; tick(); tx_if.tx_ready = 1'b0;
        m_def[g] = m_def[g] - len;
        checks++; if (get_def(g) != m_def[g]) begin failures++; $display("FAIL rand_deficit: q%0d got %0d expected %0d", g, get_def(g), m_def[g]); end
        $display("test_random: run %0d grant q%0d len=%0d deficit=%0d", run, g, len, m_def[g]);
        repeat ($urandom_range(3, 0)) tick();
        void'(pk[g].pop_front());
        drive_from_model();
        tx_if.tx_done = 1'b1; tick(); tx_if.tx_done = 1'b0;
        m_after_done = 1'b1;
      end
      bad = 0;
      for (int c = 0; c < 10; c++) begin
        if (tx_if.tx_valid === 1'b1) bad++;
        tick();
      end
      checks++; if (bad != 0) begin failures++; $display("FAIL rand_drain: %0d extra grant cycles, expected 0", bad); end
    end
  endtask

  initial begin
    test_reset();
    test_order();
    test_accumulate();
    test_stall();
    test_drop();
    test_rst_mid();
    test_sched_en();
    test_zero_quantum();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
